sound_channels: RTL and testbench

Parametrised multi-channel sound-effect generator replacing hand-wired per-effect gating in the game's audio path. Each channel is triggered by an active-low game event, stays active for a fixed cycle count or until an end event, and gates its own tone reference (a video counter bit or any square wave). Active channels are mixed by OR or fixed priority, muted during attract mode, and delivered as a registered 1-bit `SOUND` to the board audio output.

---
 rtl/sound_channels.sv | 116 +++++++++++
 tb/tb_sound_channels.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sound_channels.sv
// sound_channels: multi-channel triggered tone gating with OR/priority mix and mute
module sound_channels #(
  parameter int                          NUM_CH     = 3,
  parameter int                          DUR_W      = 22,
  parameter logic [NUM_CH*DUR_W-1:0]     DUR_COUNTS = '0,
  parameter int                          MIX_MODE   = 0,
  parameter int                          RETRIGGER  = 1,
  localparam int                         SW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK_DRV,
  input  logic              RESET_N,
  input  logic [NUM_CH-1:0] TRIG_N,
  input  logic [NUM_CH-1:0] END_EV,
  input  logic [NUM_CH-1:0] TONE,
  input  logic              MUTE_N,
  output logic [NUM_CH-1:0] ACTIVE,
  output logic [SW-1:0]     CH_SEL,
  output logic              SOUND
);
  typedef enum logic {IDLE, RUN} st_e;
  st_e              st_q   [NUM_CH];
  st_e              st_d   [NUM_CH];
  logic [DUR_W-1:0] cnt_q  [NUM_CH];
  logic [DUR_W-1:0] cnt_d  [NUM_CH];
  logic [DUR_W-1:0] dur    [NUM_CH];
  logic [DUR_W-1:0] reload [NUM_CH];
  logic [NUM_CH-1:0] trig_q, end_q, trig, endv, gate;
  logic [SW-1:0]     k, ch_sel_q, ch_sel_d;
  logic              any, mix, sound_q, sound_d;

  assign trig   = trig_q & ~TRIG_N;
  assign endv   = ~end_q & END_EV;
  assign gate   = ACTIVE & TONE;
  assign CH_SEL = ch_sel_q;
  assign SOUND  = sound_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign dur[g]    = DUR_COUNTS[g*DUR_W +: DUR_W];
    assign reload[g] = (dur[g] != '0) ? dur[g] - DUR_W'(1) : '0;
    assign ACTIVE[g] = (st_q[g] == RUN);
  end

  // previous samples for falling-trigger / rising-end detection; end starts high so held levels never fire
  always_ff @(posedge CLK_DRV or negedge RESET_N) begin
    if (!RESET_N) begin
      trig_q <= '0;
      end_q  <= '1;
    end else begin
      trig_q <= TRIG_N;
      end_q  <= END_EV;
    end
  end

  // channel state and duration counters
  always_ff @(posedge CLK_DRV or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= IDLE;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // per-channel next state: a trigger outranks terminal count or end event when retriggering is enabled
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      if (st_q[i] == IDLE) begin
        if (trig[i]) begin
          st_d[i]  = RUN;
          cnt_d[i] = reload[i];
        end
      end else if (trig[i] && RETRIGGER != 0) begin
        cnt_d[i] = reload[i];
      end else if (dur[i] == '0) begin
        st_d[i] = endv[i] ? IDLE : RUN;
      end else if (cnt_q[i] == '0) begin
        st_d[i] = IDLE;
      end else begin
        cnt_d[i] = cnt_q[i] - DUR_W'(1);
      end
    end
  end

  // mixer: lowest active channel owns the output in priority mode, even during its silent tone phase
  always_comb begin
    k   = '0;
    any = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ACTIVE[i]) begin
        k   = SW'(i);
        any = 1'b1;
      end
    end
    mix      = (MIX_MODE != 0) ? (any & gate[k]) : |gate;
    sound_d  = MUTE_N & mix;
    ch_sel_d = (MIX_MODE != 0) ? k : '0;
  end

  // registered audio bit and selected channel
  always_ff @(posedge CLK_DRV or negedge RESET_N) begin
    if (!RESET_N) begin
      sound_q  <= 1'b0;
      ch_sel_q <= '0;
    end else begin
      sound_q  <= sound_d;
      ch_sel_q <= ch_sel_d;
    end
  end
endmodule

// File: tb/tb_sound_channels.sv
// tb_sound_channels: scoreboard bench for two sound_channels configurations
module tb_sound_channels;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] trig_n, end_ev, tone;
  logic       mute_n;
  logic [2:0] act_a, act_b;
  logic [1:0] sel_a, sel_b;
  logic       snd_a, snd_b;

  localparam logic [23:0] DURS = {8'd0, 8'd5, 8'd3};

  typedef struct packed {
    logic [2:0] act;
    logic       snd;
    logic [1:0] sel;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   total = 0;
  int   pass  = 0;

  int   edge_n = 0;
  int   dur[3] = '{3, 5, 0};
  bit   m_act[2][3];
  int   m_dl[2][3];
  bit   p_trig[3];
  bit   p_end[3];

  always #5 clk = ~clk;

  sound_channels #(.NUM_CH(3), .DUR_W(8), .DUR_COUNTS(DURS), .MIX_MODE(0), .RETRIGGER(1)) u_a (
    .CLK_DRV(clk), .RESET_N(rst_n), .TRIG_N(trig_n), .END_EV(end_ev), .TONE(tone),
    .MUTE_N(mute_n), .ACTIVE(act_a), .CH_SEL(sel_a), .SOUND(snd_a));

  sound_channels #(.NUM_CH(3), .DUR_W(8), .DUR_COUNTS(DURS), .MIX_MODE(1), .RETRIGGER(0)) u_b (
    .CLK_DRV(clk), .RESET_N(rst_n), .TRIG_N(trig_n), .END_EV(end_ev), .TONE(tone),
    .MUTE_N(mute_n), .ACTIVE(act_b), .CH_SEL(sel_b), .SOUND(snd_b));

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got == exp) pass++;
    else $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, got, exp);
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 3; i++) begin
        m_act[m][i] = 0;
        m_dl[m][i]  = 0;
      end
    for (int i = 0; i < 3; i++) begin
      p_trig[i] = 0;
      p_end[i]  = 1;
    end
  endtask

  // Instance 0: OR mix, retrigger on. Instance 1: priority mix, retrigger off.
  task automatic model_edge();
    exp_t e;
    bit   fire, ev, was, rt;
    edge_n++;
    for (int m = 0; m < 2; m++) begin
      rt    = (m == 0);
      e.snd = 1'b0;
      e.sel = 2'd0;
      e.act = 3'b000;
      if (m == 0) begin
        for (int i = 0; i < 3; i++) if (m_act[0][i] && tone[i]) e.snd = mute_n;
      end else begin
        for (int i = 2; i >= 0; i--)
          if (m_act[1][i]) begin
            e.sel = 2'(i);
            e.snd = mute_n & tone[i];
          end
      end
      for (int i = 0; i < 3; i++) begin
        fire = p_trig[i] && !trig_n[i];
        ev   = !p_end[i] && end_ev[i];
        was  = m_act[m][i];
        if (dur[i] > 0) begin
          if (fire && (!was || rt)) m_dl[m][i] = edge_n + dur[i];
          m_act[m][i] = (edge_n < m_dl[m][i]);
        end else begin
          m_act[m][i] = (fire && (!was || rt)) ? 1'b1 : (was && !ev);
        end
        e.act[i] = m_act[m][i];
      end
      if (m == 0) q_a.push_back(e);
      else q_b.push_back(e);
    end
    for (int i = 0; i < 3; i++) begin
      p_trig[i] = trig_n[i];
      p_end[i]  = end_ev[i];
    end
  endtask

  task automatic step(input logic [2:0] tn, input logic [2:0] ev, input logic [2:0] t, input logic m);
    @(negedge clk);
    rst_n  = 1'b1;
    trig_n = tn;
    end_ev = ev;
    tone   = t;
    mute_n = m;
    model_edge();
  endtask

  // monitor: every clock the DUTs present a fresh output; compare against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        chk("A.active", act_a, e.act);
        chk("A.sound", snd_a, e.snd);
        chk("A.ch_sel", sel_a, e.sel);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        chk("B.active", act_b, e.act);
        chk("B.sound", snd_b, e.snd);
        chk("B.ch_sel", sel_b, e.sel);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    trig_n = 3'b111;
    end_ev = 3'b000;
    tone   = 3'b111;
    mute_n = 1'b1;
    model_reset();
    #1;
    chk("reset.A.active", act_a, 0);
    chk("reset.B.active", act_b, 0);
    chk("reset.A.sound", snd_a, 0);
    chk("reset.B.sound", snd_b, 0);
    chk("reset.A.ch_sel", sel_a, 0);
    chk("reset.B.ch_sel", sel_b, 0);
    repeat (2) @(posedge clk);
    step(3'b111, 3'b000, 3'b111, 1'b1);
    // ch1 and ch2 fire, ch1 refires three edges later, ch0 fires at edge 10, ch2 ends at edge 20
    step(3'b001, 3'b000, 3'b111, 1'b1);
    repeat (2) step(3'b011, 3'b000, 3'b111, 1'b1);
    step(3'b001, 3'b000, 3'b111, 1'b1);
    repeat (6) step(3'b011, 3'b000, 3'b111, 1'b1);
    step(3'b010, 3'b000, 3'b111, 1'b1);
    repeat (9) step(3'b011, 3'b000, 3'b111, 1'b1);
    step(3'b011, 3'b100, 3'b111, 1'b1);
    repeat (3) step(3'b111, 3'b100, 3'b111, 1'b1);
    // ch2 again, then trigger and end in the same cycle
    step(3'b011, 3'b000, 3'b111, 1'b1);
    repeat (3) step(3'b111, 3'b000, 3'b111, 1'b1);
    step(3'b011, 3'b100, 3'b111, 1'b1);
    repeat (3) step(3'b111, 3'b100, 3'b111, 1'b1);
    step(3'b111, 3'b000, 3'b111, 1'b1);
    step(3'b111, 3'b100, 3'b111, 1'b1);
    step(3'b111, 3'b000, 3'b111, 1'b1);
    // priority masking: ch0 silent, ch1 sounding
    step(3'b100, 3'b000, 3'b110, 1'b1);
    repeat (8) step(3'b111, 3'b000, 3'b110, 1'b1);
    // mute while ch1 runs
    step(3'b101, 3'b000, 3'b111, 1'b1);
    repeat (2) step(3'b111, 3'b000, 3'b111, 1'b0);
    repeat (4) step(3'b111, 3'b000, 3'b111, 1'b1);
    // reset mid-run with triggers held low through release
    step(3'b101, 3'b000, 3'b111, 1'b1);
    step(3'b111, 3'b000, 3'b111, 1'b1);
    @(posedge clk);
    #2;
    rst_n  = 1'b0;
    trig_n = 3'b000;
    model_reset();
    #1;
    chk("midreset.A.active", act_a, 0);
    chk("midreset.B.active", act_b, 0);
    chk("midreset.A.sound", snd_a, 0);
    chk("midreset.B.ch_sel", sel_b, 0);
    repeat (2) @(posedge clk);
    repeat (4) step(3'b000, 3'b000, 3'b111, 1'b1);
    step(3'b111, 3'b000, 3'b111, 1'b1);
    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic [2:0] tn, ev, t;
      for (int i = 0; i < 3; i++) begin
        tn[i] = ($urandom_range(0, 3) != 0);
        ev[i] = ($urandom_range(0, 4) == 0);
      end
      t = 3'($urandom);
      step(tn, ev, t, $urandom_range(0, 7) != 0);
    end
    @(posedge clk);
    #2;
    chk("drain.A", q_a.size(), 0);
    chk("drain.B", q_b.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
